vote_result_reader: RTL

Reads the four candidate tallies maintained by `vote_logger` and announces them. On a start request, it snapshots all four counts and streams them out in order over a valid/ready handshake, then sends a winner record. It sits between the vote logger and the display or transmit path of the EVM, and is the read side of the tally registers.

---
 rtl/vote_pkg.sv | 20 ++
 rtl/vote_result_reader_if.sv | 12 +
 rtl/vote_max_finder.sv | 33 +++
 rtl/vote_result_reader.sv | 98 +++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared constants, tags and FSM encoding for the EVM result reader.
package vote_pkg;

    localparam int NUM_CAND        = 4;
    localparam int COUNT_W_DEFAULT = 8;

    localparam logic [2:0] TAG_C1  = 3'd0;
    localparam logic [2:0] TAG_C2  = 3'd1;
    localparam logic [2:0] TAG_C3  = 3'd2;
    localparam logic [2:0] TAG_C4  = 3'd3;
    localparam logic [2:0] TAG_WIN = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WIN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vote_result_reader_if.sv
// Tagged result stream carrying the four counts and the winner record.
interface vote_result_reader_if #(
    parameter int COUNT_W = vote_pkg::COUNT_W_DEFAULT
);
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] out_data;
    logic [2:0]         out_tag;

    modport master (output out_valid, output out_data, output out_tag, input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_tag, output out_ready);
endinterface

// File: rtl/vote_max_finder.sv
// Combinational arg-max over the candidate counts; lowest index wins ties.
module vote_max_finder
    import vote_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic [NUM_CAND-1:0][COUNT_W-1:0] counts,
    output logic [1:0]                       winner,
    output logic                             tie
);

    logic [COUNT_W-1:0] best_val;
    int                 hits;

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path leaves it unassigned and infers a latch.
        winner   = 2'd0;
        best_val = counts[0];
        hits     = 0;
        // Strict '>' keeps the earliest candidate when later ones only match the maximum.
        for (int i = 1; i < NUM_CAND; i++) begin
            if (counts[i] > best_val) begin
                best_val = counts[i];
                winner   = 2'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (counts[i] == best_val) hits = hits + 1;
        end
        tie = (hits > 1);
    end

endmodule

// File: rtl/vote_result_reader.sv
// Snapshots the four tallies on start and streams them, then a winner record.
module vote_result_reader
    import vote_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] vote_count_c1,
    input  logic [COUNT_W-1:0] vote_count_c2,
    input  logic [COUNT_W-1:0] vote_count_c3,
    input  logic [COUNT_W-1:0] vote_count_c4,
    vote_result_reader_if.master out,
    output logic [1:0]         winner,
    output logic               tie,
    output logic               busy,
    output logic               done
);

    state_t                          state;
    state_t                          state_next;
    logic [1:0]                      idx;
    logic [NUM_CAND-1:0][COUNT_W-1:0] live_counts;
    logic [NUM_CAND-1:0][COUNT_W-1:0] snapshot;
    logic [1:0]                      cap_winner;
    logic                            cap_tie;
    logic                            capture;

    assign live_counts = {vote_count_c4, vote_count_c3, vote_count_c2, vote_count_c1};
    assign capture     = (state == IDLE) && start;

    vote_max_finder #(.COUNT_W(COUNT_W)) u_max_finder (
        .counts (live_counts),
        .winner (cap_winner),
        .tie    (cap_tie)
    );

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (out.out_ready && idx == 2'd3) state_next = WIN;
            WIN:     if (out.out_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the snapshot is only four words, so it is reset like any other register; deep arrays would not be.
        if (!reset) begin
            snapshot <= '0;
            idx      <= 2'd0;
            winner   <= 2'd0;
            tie      <= 1'b0;
        end else if (capture) begin
            snapshot <= live_counts;
            idx      <= 2'd0;
            winner   <= cap_winner;
            tie      <= cap_tie;
        end else if (state == SEND && out.out_ready && idx != 2'd3) begin
            idx <= idx + 2'd1;
        end
    end

    // Outputs decode registered state only, so out_valid never follows out_ready combinationally.
    always_comb begin
        out.out_valid = 1'b0;
        out.out_data  = '0;
        out.out_tag   = TAG_C1;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            SEND: begin
                out.out_valid = 1'b1;
                out.out_data  = snapshot[idx];
                out.out_tag   = {1'b0, idx};
                busy          = 1'b1;
            end
            WIN: begin
                out.out_valid = 1'b1;
                out.out_data  = COUNT_W'({tie, winner});
                out.out_tag   = TAG_WIN;
                busy          = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
